// File: rtl/z80_block_pkg.sv
// Shared definitions for the Z80 block-transfer (LDI/LDD/LDIR/LDDR) engine.
package z80_block_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_UPDATE,
        ST_FINISH
    } xfer_state_t;

    // F register bit positions touched by the block-transfer instructions
    localparam int FLAG_N  = 1;
    localparam int FLAG_PV = 2;
    localparam int FLAG_H  = 4;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_DEC  = 1'b1;
    localparam logic MODE_ONCE = 1'b0;
    localparam logic MODE_RPT  = 1'b1;

endpackage

// File: rtl/z80_block_addr_step.sv
// Modular +/-1 stepper for the HL and DE pointers; wraps silently at either end.
module z80_block_addr_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic [W-1:0] result
);

    always_comb begin
        if (dec) result = value - W'(1);
        else     result = value + W'(1);
    end

endmodule

// File: rtl/z80_block_xfer.sv
// Z80 block-transfer engine: one byte per READ/WRITE/UPDATE pass, optional repeat.
//
// state     | meaning
// ST_IDLE   | waiting for start, inputs latched on start
// ST_READ   | read request at HL until mem_rd_ack
// ST_WRITE  | write captured byte to DE until mem_wr_ack
// ST_UPDATE | step HL/DE/BC, update flags, decide repeat or finish
// ST_FINISH | one-cycle done pulse
module z80_block_xfer
    import z80_block_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_dec,
    input  logic              mode_rpt,
    input  logic [ADDR_W-1:0] hl_in,
    input  logic [ADDR_W-1:0] de_in,
    input  logic [CNT_W-1:0]  bc_in,
    input  logic [7:0]        f_in,
    input  logic              irq_pending,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    input  logic              mem_wr_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] hl_out,
    output logic [ADDR_W-1:0] de_out,
    output logic [CNT_W-1:0]  bc_out,
    output logic [7:0]        f_out,
    output logic              interrupted
);

    xfer_state_t       state_q, state_d;
    logic [ADDR_W-1:0] hl_q, de_q;
    logic [ADDR_W-1:0] hl_step, de_step;
    logic [CNT_W-1:0]  bc_q, bc_step;
    logic [7:0]        f_q;
    logic [7:0]        data_q;
    logic              dec_q, rpt_q, intr_q;
    logic              bc_nz;
    logic              step_dec;

    assign step_dec = (dec_q == MODE_DEC);
    assign bc_step  = bc_q - CNT_W'(1);
    assign bc_nz    = (bc_step != '0);

    z80_block_addr_step #(.W(ADDR_W)) u_hl_step (
        .value  (hl_q),
        .dec    (step_dec),
        .result (hl_step)
    );

    z80_block_addr_step #(.W(ADDR_W)) u_de_step (
        .value  (de_q),
        .dec    (step_dec),
        .result (de_step)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)      state_d = ST_READ;
            ST_READ:   if (mem_rd_ack) state_d = ST_WRITE;
            ST_WRITE:  if (mem_wr_ack) state_d = ST_UPDATE;
            ST_UPDATE: begin
                if ((rpt_q == MODE_RPT) && bc_nz && !irq_pending) state_d = ST_READ;
                else                                             state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hl_q    <= '0;
            de_q    <= '0;
            bc_q    <= '0;
            f_q     <= '0;
            data_q  <= '0;
            dec_q   <= MODE_INC;
            rpt_q   <= MODE_ONCE;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        hl_q   <= hl_in;
                        de_q   <= de_in;
                        bc_q   <= bc_in;
                        f_q    <= f_in;
                        dec_q  <= mode_dec;
                        rpt_q  <= mode_rpt;
                        intr_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (mem_rd_ack) data_q <= mem_rd_data;
                end
                ST_UPDATE: begin
                    hl_q        <= hl_step;
                    de_q        <= de_step;
                    bc_q        <= bc_step;
                    f_q[FLAG_H] <= 1'b0;
                    f_q[FLAG_N] <= 1'b0;
                    f_q[FLAG_PV] <= bc_nz;
                    intr_q      <= (rpt_q == MODE_RPT) & bc_nz & irq_pending;
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_req  = (state_q == ST_READ);
    assign mem_wr_req  = (state_q == ST_WRITE);
    assign mem_rd_addr = hl_q;
    assign mem_wr_addr = de_q;
    assign mem_wr_data = data_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign hl_out      = hl_q;
    assign de_out      = de_q;
    assign bc_out      = bc_q;
    assign f_out       = f_q;
    assign interrupted = intr_q;

endmodule

// File: doc/z80_block_xfer.md
Z80_BLOCK_XFER -- requirements
Module: z80_block_xfer

Interface
REQ-001 Parameter ADDR_W, default 16: width of HL/DE/address buses.
REQ-002 Parameter CNT_W, default 16: width of BC byte counter.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin an instruction; sampled only in IDLE.
REQ-006 mode_dec  in  1  0 = HL/DE increment (LDI/LDIR), 1 = decrement (LDD/LDDR); latched at start.
REQ-007 mode_rpt  in  1  1 = repeat until BC == 0 (LDIR/LDDR); latched at start.
REQ-008 hl_in, de_in  in  ADDR_W  source/destination addresses; bc_in  in  CNT_W  count; f_in  in  8  flags; all latched at start.
REQ-009 irq_pending  in  1  interrupt request; sampled at iteration end.
REQ-010 mem_rd_req  out  1; mem_rd_addr  out  ADDR_W; mem_rd_ack  in  1; mem_rd_data  in  8.
REQ-011 mem_wr_req  out  1; mem_wr_addr  out  ADDR_W; mem_wr_data  out  8; mem_wr_ack  in  1.
REQ-012 busy  out  1  high from cycle after accepted start until done cycle, inclusive.
REQ-013 done  out  1  one-cycle pulse at instruction completion.
REQ-014 hl_out, de_out  out  ADDR_W; bc_out  out  CNT_W; f_out  out  8: live working registers, final values valid when done = 1.
REQ-015 interrupted  out  1  valid with done: repeat cut short, caller rewinds PC by 2 (else PC advances by 2).

Function
REQ-016 FSM states: IDLE, READ, WRITE, UPDATE, FINISH.
REQ-017 IDLE: start = 1 latches inputs, goes to READ next cycle; start ignored in any other state.
REQ-018 READ: mem_rd_req = 1, mem_rd_addr = HL; on mem_rd_ack capture mem_rd_data, go to WRITE; req held stable until ack.
REQ-019 WRITE: mem_wr_req = 1, mem_wr_addr = DE, mem_wr_data = captured byte; on mem_wr_ack go to UPDATE.
REQ-020 Never assert mem_rd_req and mem_wr_req in the same cycle.
REQ-021 UPDATE (one cycle): HL ± 1, DE ± 1 (mod 2^ADDR_W), BC − 1 (mod 2^CNT_W).
REQ-022 UPDATE flags: H (bit 4) = 0, N (bit 1) = 0, P/V (bit 2) = (BC_new != 0); S, Z, C, bits 5/3 unchanged from latched F.
REQ-023 After UPDATE: if mode_rpt and BC_new != 0 and irq_pending = 0 -> READ; else -> FINISH.
REQ-024 interrupted = mode_rpt & (BC_new != 0) & irq_pending, registered at UPDATE exit.
REQ-025 FINISH: done = 1 for one cycle, then IDLE.
REQ-026 bc_in == 0 with mode_rpt = 1: 2^CNT_W transfers (wrap); P/V = 0 at end.
REQ-027 Address wrap: HL/DE at all-ones increment to 0; at 0 decrement to all-ones; no error.
REQ-028 Minimum latency with same-cycle acks: 3 cycles per byte plus 1 FINISH cycle; LDI with acks same-cycle -> done 4 cycles after start cycle.
REQ-029 Ack received in a state not waiting for it: ignored.

Reset
REQ-030 reset = 1 forces IDLE on next edge, also mid-transfer; pending bus request dropped, no completion of partial iteration.
REQ-031 Reset values: mem_rd_req = mem_wr_req = busy = done = interrupted = 0; hl_out, de_out, bc_out, f_out, addresses, mem_wr_data = 0.
REQ-032 reset dominates start in the same cycle.

Structure
REQ-033 Package z80_block_pkg: FSM state enum, flag bit positions (H = 4, P/V = 2, N = 1), mode encoding constants.
REQ-034 Single sub-module z80_block_addr_step: parametrised ±1 stepper used for HL and DE.
REQ-035 No other hierarchy; all registers in one clocked process.

Verification
REQ-036 LDI: HL=1000h, DE=2000h, BC=0001h, F=FFh, mem[1000h]=5Ah, acks same cycle -> mem[2000h]=5Ah, HL=1001h, DE=2001h, BC=0, F=E9h, done at cycle 4.
REQ-037 LDDR: HL=10FFh, DE=20FFh, BC=0003h -> 3 bytes copied downward, HL=10FCh, DE=20FCh, BC=0, P/V=0, interrupted=0.
REQ-038 LDIR with irq_pending raised during 2nd iteration, BC=0005h -> stop after 2nd UPDATE, BC=0003h, P/V=1, interrupted=1.
REQ-039 Wait states: rd_ack delayed 3 cycles, wr_ack 2 cycles -> requests/addresses stable throughout, single byte written, never both reqs high.
REQ-040 Reset asserted while in WRITE -> next cycle all reqs 0, busy 0, no write ack consumed; subsequent start runs normally.
REQ-041 Wrap: LDI with HL=FFFFh, DE=0000h decrement mode, BC=0000h non-repeat -> HL=FFFEh, DE=FFFFh, BC=FFFFh, P/V=1.
